pwl_act_simd: RTL
=================

Name: pwl_act_simd

Overview:
Parametrised successor to the fixed 2-lane, 5-slice tanh pipeline. It is a LANES-wide SIMD piecewise-linear activation unit with a run-time programmable slope/intercept table and a per-beat mode select (tanh or sigmoid). It uses a 4-stage pipeline with valid/ready backpressure. It sits between the MAC array output and the activation writeback buffer.

Parameters:
LANES, 2, number of parallel lanes.
DW, 16, sample width, signed fixed point.
FRAC, 11, fractional bits (Q5.11 at defaults); ONE = 2^FRAC.
SLICES, 5, number of table segments over |x|.
SEG_SHIFT, 11, log2 of segment width in LSBs (defaults give 1.0 per segment).
AW, 3, table address width; must satisfy 2^AW >= SLICES.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit accepts a beat this cycle
in_mode  in  1  0 = tanh, 1 = sigmoid; travels with the beat
x_in  in  LANES*DW  packed inputs; lane k occupies bits [k*DW +: DW]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
y_out  out  LANES*DW  packed results, same packing as x_in
cfg_we  in  1  table write strobe
cfg_addr  in  AW  segment index
cfg_slope  in  DW  signed slope, Q(FRAC)
cfg_icpt  in  DW  signed intercept, Q(FRAC)

Behaviour:
- Reset:
  - Clears all stage valids, out_valid, y_out and every table entry to 0.
  - in_ready is 1 on the first cycle after reset.
  - Reset asserted mid-operation flushes all in-flight beats; nothing is emitted for them.
- Pipeline advance: en = out_ready | ~out_valid; in_ready = en. All four stages advance together on en; nothing moves when en = 0.
- Accept: a beat is accepted on a cycle with in_valid & in_ready.
- Latency: an accepted beat appears on y_out with out_valid exactly 4 cycles later when en stays 1. Throughput is 1 beat per cycle.
- Stage S0 (per lane):
  - xs = in_mode ? (x >>> 1) : x.
  - sign = xs[DW-1].
  - a = |xs|; the most negative value saturates to 2^(DW-1)-1.
  - idx = a >> SEG_SHIFT.
  - sat = (idx >= SLICES).
- Stage S1: read slope[idx] and icpt[idx]; p = slope * a, computed as a signed product of width 2*DW+1.
- Stage S2:
  - t = ((p + 2^(FRAC-1)) >>> FRAC) + icpt.
  - Clamp t to [0, ONE].
  - If sat, t = ONE, ignoring the table.
- Stage S3:
  - tanh mode: y = sign ? -t : t.
  - sigmoid mode: s = sign ? ONE - t : ONE + t, then y = (s + 1) >> 1.
  - y is registered into y_out.
- Mode and sign are pipelined alongside the data of their own beat. Mixed modes in consecutive beats are legal.
- Table access:
  - Writes when cfg_we = 1, regardless of en.
  - Out-of-range cfg_addr (>= SLICES) is ignored.
  - A write is visible to any beat whose S1 read occurs on a later cycle. The S1 read uses the S0-registered idx. A beat in S1 on the same cycle as the write sees the old value.
- Backpressure:
  - While out_valid = 1 and out_ready = 0: y_out and out_valid hold stable and in_ready = 0.
  - When out_ready rises, the held beat completes that cycle and the pipe advances.
  - Bubbles do not unblock in_ready while out_valid is held; this is the simple global-stall rule.
- Lanes are fully independent; there is no cross-lane arithmetic.

Test Plan:
- Identity table (all slope = 2048, icpt = 0), tanh mode, LANES = 2. Beat x = {0x0400 (0.5), 0x1800 (3.0)} -> y = {0x0400, 0x0800}; the 3.0 lane clamps to ONE. out_valid rises 4 cycles after accept.
- Program slope[0] = 1560, icpt[0] = 0, tanh mode. x = {0x0400, 0xFC00 (-0.5)} -> y = {780, -780}. x = {0x2800 (5.0), 0xD800 (-5.0)} -> y = {2048, -2048} via sat. x = 0x8000 -> -2048.
- Same table, sigmoid mode. x = {0, 0x0800 (1.0)} -> y = {1024, 1414}. x = 0xF800 (-1.0) -> (2048 - 780 + 1) >> 1 = 634.
- 10 back-to-back beats with out_ready toggling in a 1-0-0-1 pattern and alternating in_mode. Required: every result matches the model, order is preserved, no duplicates or drops, and y_out stays stable while stalled.
- Rewrite slope[0] with cfg_we while a stream is flowing. Required: beats reading S1 before the write cycle use the old value, later beats use the new value. A write with cfg_addr = 6 leaves the table unchanged.
- Assert rst for 1 cycle with 3 beats in flight. Required: out_valid = 0 and y_out = 0 on the next cycle, no flushed beat is emitted, the table reads zero (x = 0x0400 -> 0), and in_ready = 1.

Source files
------------

// File: rtl/pwl_act_simd.sv
// pwl_act_simd: LANES-wide piecewise-linear tanh/sigmoid activation unit.
// Four register stages share a single advance enable, so a stalled output
// freezes the whole pipe. One slope/intercept table serves every lane and
// can be rewritten at any time; entries are indexed by |x| >> SEG_SHIFT.
module pwl_act_simd #(
    parameter int LANES     = 2,
    parameter int DW        = 16,
    parameter int FRAC      = 11,
    parameter int SLICES    = 5,
    parameter int SEG_SHIFT = 11,
    parameter int AW        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [LANES*DW-1:0] x_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] y_out,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [DW-1:0]       cfg_slope,
    input  logic [DW-1:0]       cfg_icpt
);
    localparam int IW    = DW - SEG_SHIFT;   // width of the segment index
    localparam int PW    = 2 * DW + 1;       // product / rounding width
    localparam int DEPTH = 1 << AW;
    localparam int ONE   = 1 << FRAC;

    localparam logic signed [PW-1:0] P_RND   = PW'(ONE / 2);
    localparam logic signed [PW-1:0] P_ONE   = PW'(ONE);
    localparam logic        [DW:0]   P_ONE_D = (DW + 1)'(ONE);

    logic          w_en;
    logic          r_v0, r_v1, r_v2, r_v3;
    logic          r_mode0, r_mode1, r_mode2;
    logic [DW-1:0] r_slope [DEPTH];
    logic [DW-1:0] r_icpt  [DEPTH];

    // Global stall: everything moves only when the output slot can drain
    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;
    assign out_valid = r_v3;

    // Beat valid and mode bits travel alongside the lane data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_mode0 <= 1'b0;
            r_mode1 <= 1'b0;
            r_mode2 <= 1'b0;
        end else if (w_en) begin
            r_v0    <= in_valid;
            r_v1    <= r_v0;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_mode0 <= in_mode;
            r_mode1 <= r_mode0;
            r_mode2 <= r_mode1;
        end
    end

    // Table writes ignore the stall; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_slope[i] <= '0;
                r_icpt[i]  <= '0;
            end
        end else if (cfg_we && (int'(cfg_addr) < SLICES)) begin
            r_slope[cfg_addr] <= cfg_slope;
            r_icpt[cfg_addr]  <= cfg_icpt;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DW-1:0] w_x, w_xs;
        logic        [DW-1:0] w_a;
        logic        [IW-1:0] w_idx;
        logic                 w_sat;
        logic        [AW-1:0] r_addr0;
        logic        [DW-1:0] r_a0;
        logic                 r_sat0, r_sign0;
        logic signed [PW-1:0] w_slope_ext, w_a_ext, w_p;
        logic signed [PW-1:0] r_p1;
        logic        [DW-1:0] r_icpt1;
        logic                 r_sat1, r_sign1;
        logic signed [PW-1:0] w_icpt_ext, w_t;
        logic        [DW-1:0] w_t_next, r_t2;
        logic                 r_sign2;
        logic        [DW:0]   w_s, w_s1;
        logic        [DW-1:0] w_y_next, r_y;

        assign w_x = x_in[gi*DW +: DW];

        // S0 comb: sigmoid halves x, then magnitude and segment lookup
        always_comb begin
            w_xs = in_mode ? (w_x >>> 1) : w_x;
            if (w_xs == {1'b1, {(DW-1){1'b0}}}) begin
                w_a = {1'b0, {(DW-1){1'b1}}};
            end else if (w_xs[DW-1]) begin
                w_a = -w_xs;
            end else begin
                w_a = w_xs;
            end
            w_idx = w_a[DW-1:SEG_SHIFT];
            w_sat = (int'(w_idx) >= SLICES);
        end

        // S0 register; saturated beats read entry 0, which S2 then ignores
        always_ff @(posedge clk) begin
            if (rst) begin
                r_addr0 <= '0;
                r_a0    <= '0;
                r_sat0  <= 1'b0;
                r_sign0 <= 1'b0;
            end else if (w_en) begin
                r_addr0 <= w_sat ? '0 : w_idx[AW-1:0];
                r_a0    <= w_a;
                r_sat0  <= w_sat;
                r_sign0 <= w_xs[DW-1];
            end
        end

        // S1 comb: table read with the registered index, signed product
        always_comb begin
            w_slope_ext = {{(PW-DW){r_slope[r_addr0][DW-1]}}, r_slope[r_addr0]};
            w_a_ext     = {{(PW-DW){1'b0}}, r_a0};
            w_p         = w_slope_ext * w_a_ext;
        end

        // S1 register: product and intercept for this beat
        always_ff @(posedge clk) begin
            if (rst) begin
                r_p1    <= '0;
                r_icpt1 <= '0;
                r_sat1  <= 1'b0;
                r_sign1 <= 1'b0;
            end else if (w_en) begin
                r_p1    <= w_p;
                r_icpt1 <= r_icpt[r_addr0];
                r_sat1  <= r_sat0;
                r_sign1 <= r_sign0;
            end
        end

        // S2 comb: round back to Q(FRAC), add intercept, clamp to [0, ONE]
        always_comb begin
            w_icpt_ext = {{(PW-DW){r_icpt1[DW-1]}}, r_icpt1};
            w_t        = ((r_p1 + P_RND) >>> FRAC) + w_icpt_ext;
            w_t_next   = '0;
            if (r_sat1) begin
                w_t_next = DW'(ONE);
            end else if (w_t[PW-1]) begin
                w_t_next = '0;
            end else if (w_t > P_ONE) begin
                w_t_next = DW'(ONE);
            end else begin
                w_t_next = w_t[DW-1:0];
            end
        end

        // S2 register: clamped magnitude result
        always_ff @(posedge clk) begin
            if (rst) begin
                r_t2    <= '0;
                r_sign2 <= 1'b0;
            end else if (w_en) begin
                r_t2    <= w_t_next;
                r_sign2 <= r_sign1;
            end
        end

        // S3 comb: odd-symmetric tanh, or sigmoid = (1 + tanh(x/2)) / 2 rounded
        always_comb begin
            w_y_next = '0;
            w_s      = r_sign2 ? (P_ONE_D - {1'b0, r_t2}) : (P_ONE_D + {1'b0, r_t2});
            w_s1     = w_s + (DW + 1)'(1);
            if (r_mode2) begin
                w_y_next = w_s1[DW:1];
            end else begin
                w_y_next = r_sign2 ? (DW'(0) - r_t2) : r_t2;
            end
        end

        // S3 register drives y_out directly
        always_ff @(posedge clk) begin
            if (rst) begin
                r_y <= '0;
            end else if (w_en) begin
                r_y <= w_y_next;
            end
        end

        assign y_out[gi*DW +: DW] = r_y;
    end

endmodule
